// File: rtl/pkg_display_7seg.sv
// Shared definitions for the 7-segment display path.
// Glyph constants are active-high in gfedcba order (bit0 = a ... bit6 = g).
// Also defines the segment bit positions and the receiver's capture FSM states.
package pkg_display_7seg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] GLIFO_0 = 7'h3F;
  localparam logic [6:0] GLIFO_1 = 7'h06;
  localparam logic [6:0] GLIFO_2 = 7'h5B;
  localparam logic [6:0] GLIFO_3 = 7'h4F;
  localparam logic [6:0] GLIFO_4 = 7'h66;
  localparam logic [6:0] GLIFO_5 = 7'h6D;
  localparam logic [6:0] GLIFO_6 = 7'h7D;
  localparam logic [6:0] GLIFO_7 = 7'h07;
  localparam logic [6:0] GLIFO_8 = 7'h7F;
  localparam logic [6:0] GLIFO_9 = 7'h6F;
  localparam logic [6:0] GLIFO_A = 7'h77;
  localparam logic [6:0] GLIFO_B = 7'h7C;
  localparam logic [6:0] GLIFO_C = 7'h39;
  localparam logic [6:0] GLIFO_D = 7'h5E;
  localparam logic [6:0] GLIFO_E = 7'h79;
  localparam logic [6:0] GLIFO_F = 7'h71;

  typedef enum logic {
    S_ESPERA,
    S_CAPTURADO
  } estado_t;

endpackage

// File: rtl/decodificador_segmentos_hex.sv
// Combinational 7-segment to hex decoder.
//   segmentos : active-high segment pattern, gfedcba order
//   valido    : 1 when the pattern is one of the 16 hex glyphs
//   nibble    : decoded value (0 when not valid)
module decodificador_segmentos_hex
  import pkg_display_7seg::*;
(
  input  logic [6:0] segmentos,
  output logic       valido,
  output logic [3:0] nibble
);

  always_comb begin
    valido = 1'b1;
    nibble = '0;
    case (segmentos)
      GLIFO_0: nibble = 4'h0;
      GLIFO_1: nibble = 4'h1;
      GLIFO_2: nibble = 4'h2;
      GLIFO_3: nibble = 4'h3;
      GLIFO_4: nibble = 4'h4;
      GLIFO_5: nibble = 4'h5;
      GLIFO_6: nibble = 4'h6;
      GLIFO_7: nibble = 4'h7;
      GLIFO_8: nibble = 4'h8;
      GLIFO_9: nibble = 4'h9;
      GLIFO_A: nibble = 4'hA;
      GLIFO_B: nibble = 4'hB;
      GLIFO_C: nibble = 4'hC;
      GLIFO_D: nibble = 4'hD;
      GLIFO_E: nibble = 4'hE;
      GLIFO_F: nibble = 4'hF;
      default: valido = 1'b0;
    endcase
  end

endmodule

// File: rtl/receptor_display_7segmentos.sv
// Receiver for a multiplexed 4-digit 7-segment display bus.
// Registers the scanned segment/anode lines, waits for a digit slot to be
// stable for STABLE_CYCLES samples, decodes the glyph and stores it per digit.
//   i_Reloj, i_Reset      : clock, synchronous active-high reset
//   i_Segmentos[6:0]      : segment lines, gfedcba
//   i_Anodo_4_Bits[3:0]   : anode lines, bit n selects digit n
//   o_Datos_0..3          : last accepted nibble per digit
//   o_Valido[3:0]         : digit accepted at least once since reset
//   o_Error[3:0]          : last acceptance of the digit was not a hex glyph
//   o_Cuadro_Listo        : one-cycle pulse when all four digits were accepted
module receptor_display_7segmentos
  import pkg_display_7seg::*;
#(
  parameter int unsigned STABLE_CYCLES     = 4,
  parameter bit          SEG_ACTIVO_BAJO   = 1'b1,
  parameter bit          ANODO_ACTIVO_BAJO = 1'b1
) (
  input  logic       i_Reloj,
  input  logic       i_Reset,
  input  logic [6:0] i_Segmentos,
  input  logic [3:0] i_Anodo_4_Bits,
  output logic [3:0] o_Datos_0,
  output logic [3:0] o_Datos_1,
  output logic [3:0] o_Datos_2,
  output logic [3:0] o_Datos_3,
  output logic [3:0] o_Valido,
  output logic [3:0] o_Error,
  output logic       o_Cuadro_Listo
);

  localparam logic [7:0] LIMITE = 8'(STABLE_CYCLES);

  logic [6:0] seg_r, seg_p;
  logic [3:0] an_r, an_p;
  logic [7:0] cnt, cnt_sig;
  estado_t    estado, estado_sig;
  logic       captura;
  logic       un_solo_anodo;
  logic       igual;
  logic       dec_ok;
  logic [3:0] dec_nibble;
  logic [3:0] mascara, mascara_sig;
  logic [3:0] datos [4];
  logic [3:0] valido, error;
  logic       listo;

  // Input stage: normalised to active-high lit/selected, plus one sample of history.
  always_ff @(posedge i_Reloj) begin
    if (i_Reset) begin
      seg_r <= '0;
      an_r  <= '0;
      seg_p <= '0;
      an_p  <= '0;
    end else begin
      seg_r <= SEG_ACTIVO_BAJO   ? ~i_Segmentos    : i_Segmentos;
      an_r  <= ANODO_ACTIVO_BAJO ? ~i_Anodo_4_Bits : i_Anodo_4_Bits;
      seg_p <= seg_r;
      an_p  <= an_r;
    end
  end

  assign un_solo_anodo = (an_r != '0) && ((an_r & (an_r - 4'd1)) == '0);
  assign igual         = (seg_r == seg_p) && (an_r == an_p);

  decodificador_segmentos_hex u_decodificador (
    .segmentos (seg_r),
    .valido    (dec_ok),
    .nibble    (dec_nibble)
  );

  always_comb begin
    cnt_sig    = cnt;
    estado_sig = estado;
    captura    = 1'b0;
    if (!un_solo_anodo) begin
      cnt_sig    = '0;
      estado_sig = S_ESPERA;
    end else if (!igual) begin
      cnt_sig    = 8'd1;
      estado_sig = S_ESPERA;
    end else if (cnt < LIMITE) begin
      cnt_sig = cnt + 8'd1;
    end
    // Capture on the edge the counter reaches the limit; a change while in
    // S_CAPTURADO already forced the counter back to 1 above.
    if (estado == S_ESPERA && un_solo_anodo && cnt_sig == LIMITE) begin
      captura    = 1'b1;
      estado_sig = S_CAPTURADO;
    end
  end

  always_ff @(posedge i_Reloj) begin
    if (i_Reset) begin
      cnt    <= '0;
      estado <= S_ESPERA;
    end else begin
      cnt    <= cnt_sig;
      estado <= estado_sig;
    end
  end

  // an_r is one-hot whenever captura is set, so it doubles as the mask bit.
  assign mascara_sig = mascara | (captura ? an_r : 4'b0000);

  always_ff @(posedge i_Reloj) begin
    if (i_Reset) begin
      for (int unsigned i = 0; i < 4; i++) datos[i] <= '0;
      valido  <= '0;
      error   <= '0;
      mascara <= '0;
      listo   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (captura && an_r[i]) begin
          valido[i] <= 1'b1;
          error[i]  <= ~dec_ok;
          if (dec_ok) datos[i] <= dec_nibble;
        end
      end
      listo   <= (mascara_sig == 4'b1111);
      mascara <= (mascara_sig == 4'b1111) ? 4'b0000 : mascara_sig;
    end
  end

  assign o_Datos_0      = datos[0];
  assign o_Datos_1      = datos[1];
  assign o_Datos_2      = datos[2];
  assign o_Datos_3      = datos[3];
  assign o_Valido       = valido;
  assign o_Error        = error;
  assign o_Cuadro_Listo = listo;

endmodule

// File: tb/tb_receptor_display_7segmentos.sv
// Bench for receptor_display_7segmentos: two instances (active-low and
// active-high polarity, the latter fed inverted stimulus) checked every cycle
// against a sample-history model, plus literal end-of-scenario checks.
module tb_receptor_display_7segmentos;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_a;
  logic [3:0] an_a;
  logic [6:0] seg_b;
  logic [3:0] an_b;

  logic [3:0] d0_a, d1_a, d2_a, d3_a, v_a, e_a;
  logic       l_a;
  logic [3:0] d0_b, d1_b, d2_b, d3_b, v_b, e_b;
  logic       l_b;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  assign seg_b = ~seg_a;
  assign an_b  = ~an_a;

  receptor_display_7segmentos #(.STABLE_CYCLES(S), .SEG_ACTIVO_BAJO(1'b1), .ANODO_ACTIVO_BAJO(1'b1)) dut_a (
    .i_Reloj(clk), .i_Reset(rst), .i_Segmentos(seg_a), .i_Anodo_4_Bits(an_a),
    .o_Datos_0(d0_a), .o_Datos_1(d1_a), .o_Datos_2(d2_a), .o_Datos_3(d3_a),
    .o_Valido(v_a), .o_Error(e_a), .o_Cuadro_Listo(l_a));

  receptor_display_7segmentos #(.STABLE_CYCLES(S), .SEG_ACTIVO_BAJO(1'b0), .ANODO_ACTIVO_BAJO(1'b0)) dut_b (
    .i_Reloj(clk), .i_Reset(rst), .i_Segmentos(seg_b), .i_Anodo_4_Bits(an_b),
    .o_Datos_0(d0_b), .o_Datos_1(d1_b), .o_Datos_2(d2_b), .o_Datos_3(d3_b),
    .o_Valido(v_b), .o_Error(e_b), .o_Cuadro_Listo(l_b));

  // ---------------- model ----------------
  logic [6:0] glifos [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] m_dat [4];
  logic [3:0] m_val, m_err, m_mask;
  logic       m_listo;
  logic [6:0] prev_seg;
  logic [3:0] prev_an;
  int         run;

  // A digit is accepted on the edge after exactly S identical one-hot samples.
  always @(posedge clk) begin
    logic [6:0] s;
    logic [3:0] a;
    int n;
    int hit;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_dat[i] = 4'h0;
      m_val = 4'h0; m_err = 4'h0; m_mask = 4'h0; m_listo = 1'b0;
      prev_seg = 7'h00; prev_an = 4'h0; run = 1;
    end else begin
      m_listo = 1'b0;
      if (run == S && $countones(prev_an) == 1) begin
        n = 0;
        for (int i = 0; i < 4; i++) if (prev_an[i]) n = i;
        hit = -1;
        for (int g = 0; g < 16; g++) if (glifos[g] == prev_seg) hit = g;
        m_val[n] = 1'b1;
        if (hit >= 0) begin
          m_dat[n] = 4'(hit);
          m_err[n] = 1'b0;
        end else begin
          m_err[n] = 1'b1;
        end
        m_mask[n] = 1'b1;
        if (m_mask == 4'hF) begin
          m_listo = 1'b1;
          m_mask  = 4'h0;
        end
      end
      s = ~seg_a;
      a = ~an_a;
      if (s == prev_seg && a == prev_an) begin
        if (run <= S) run = run + 1;
      end else begin
        prev_seg = s;
        prev_an  = a;
        run      = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string t, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3, input logic [3:0] v,
                         input logic [3:0] e, input logic l);
    chk({t, ".datos0"}, 32'(d0), 32'(m_dat[0]));
    chk({t, ".datos1"}, 32'(d1), 32'(m_dat[1]));
    chk({t, ".datos2"}, 32'(d2), 32'(m_dat[2]));
    chk({t, ".datos3"}, 32'(d3), 32'(m_dat[3]));
    chk({t, ".valido"}, 32'(v),  32'(m_val));
    chk({t, ".error"},  32'(e),  32'(m_err));
    chk({t, ".listo"},  32'(l),  32'(m_listo));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp_dut("a", d0_a, d1_a, d2_a, d3_a, v_a, e_a, l_a);
      cmp_dut("b", d0_b, d1_b, d2_b, d3_b, v_b, e_b, l_b);
      if (l_a === 1'b1) pulses++;
    end
  end

  // ---------------- stimulus ----------------
  // an/seg given in active-low form (as driven to dut_a).
  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_a  = an;
    seg_a = seg;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p0;
    rst   = 1'b1;
    seg_a = 7'h7F;
    an_a  = 4'hF;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    chk("reset_valido", 32'(v_a), 32'h0);
    chk("reset_datos0", 32'(d0_a), 32'h0);
    rst = 1'b0;

    // Scan digits 0..3 showing 1,2,3,4.
    hold(4'hE, 7'h79, 8);
    hold(4'hD, 7'h24, 8);
    hold(4'hB, 7'h30, 8);
    hold(4'h7, 7'h19, 8);
    hold(4'hF, 7'h7F, 4);
    chk("s1_datos0", 32'(d0_a), 32'h1);
    chk("s1_datos1", 32'(d1_a), 32'h2);
    chk("s1_datos2", 32'(d2_a), 32'h3);
    chk("s1_datos3", 32'(d3_a), 32'h4);
    chk("s1_valido", 32'(v_a), 32'hF);
    chk("s1_error",  32'(e_a), 32'h0);
    chk("s1_pulsos", 32'(pulses), 32'd1);

    // Stability threshold: 3 samples is too short, 4 is enough.
    hold(4'hE, 7'h40, 3);
    hold(4'hF, 7'h7F, 6);
    chk("s2_corto", 32'(d0_a), 32'h1);
    hold(4'hE, 7'h40, 4);
    hold(4'hF, 7'h7F, 6);
    chk("s2_justo", 32'(d0_a), 32'h0);

    // Blanking and multi-hot anodes never capture.
    p0 = pulses;
    hold(4'hF, 7'h7F, 10);
    hold(4'hC, 7'h79, 10);
    chk("s3_valido", 32'(v_a), 32'hF);
    chk("s3_pulsos", 32'(pulses), 32'(p0));
    chk("s3_datos0", 32'(d0_a), 32'h0);

    // Undecodable glyph on digit 2.
    hold(4'hB, 7'h7E, 8);
    hold(4'hF, 7'h7F, 4);
    chk("s4_error",  32'(e_a), 32'h4);
    chk("s4_datos2", 32'(d2_a), 32'h3);
    // Digits 0 and 2 are already masked, so 1 and 3 complete the frame.
    p0 = pulses;
    hold(4'hD, 7'h24, 8);
    hold(4'h7, 7'h19, 8);
    hold(4'hF, 7'h7F, 4);
    chk("s4_cuadro", 32'(pulses), 32'(p0 + 1));
    chk("s4_error3", 32'(e_a), 32'h4);

    // Frozen digit 1, then reset in the middle of the hold.
    p0 = pulses;
    hold(4'hD, 7'h24, 100);
    chk("s5_pulsos", 32'(pulses), 32'(p0));
    chk("s5_datos1", 32'(d1_a), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    chk("s5_rst_valido", 32'(v_a), 32'h0);
    chk("s5_rst_datos1", 32'(d1_a), 32'h0);
    chk("s5_rst_error",  32'(e_a), 32'h0);
    rst = 1'b0;
    hold(4'hD, 7'h24, 3);
    chk("s5_temprano", 32'(v_a), 32'h0);
    hold(4'hD, 7'h24, 3);
    chk("s5_recaptura_v", 32'(v_a), 32'h2);
    chk("s5_recaptura_d", 32'(d1_a), 32'h2);
    hold(4'hF, 7'h7F, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
